i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
// - I2C responder (target) matching the on-board i2c_master. Serves an 8-bit-addressed register window to an external I2C initiator.
// - Decodes START/STOP, address, pointer and data bytes from open-drain SCL/SDA; issues single-cycle register read/write strobes.
// - Drives SDA only for ACK and read data. Never drives SCL (no clock stretching).
// PARAMETERS
// - DEV_ADDR    7'h50  7-bit device address answered by this block
// - FILTER_LEN  4      consecutive equal clk samples required to accept an SCL/SDA level (1..15)
// PORTS
// - clk          in   1  system clock; must be >= 16x SCL rate
// - rst_n        in   1  asynchronous active-low reset
// - scl_i        in   1  SCL pad input
// - sda_i        in   1  SDA pad input
// - sda_o        out  1  SDA drive value; always 0
// - sda_t        out  1  SDA tristate; 1 = released, 0 = drive sda_o
// - reg_addr     out  8  register pointer; valid with reg_wr_en/reg_rd_en
// - reg_wr_en    out  1  one-cycle write strobe
// - reg_wr_data  out  8  write data; valid with reg_wr_en
// - reg_rd_en    out  1  one-cycle read strobe
// - reg_rd_data  in   8  read data; sampled exactly 1 clk after reg_rd_en
// - busy         out  1  high from address match to STOP/START
// BEHAVIOUR
// - Reset values (async, rst_n low): sda_o=0, sda_t=1, reg_addr=0, reg_wr_en=0, reg_wr_data=0, reg_rd_en=0, busy=0. FSM=IDLE, filtered SCL/SDA=1.
// - Input path: 2-FF synchroniser, then stability filter. A level is accepted after FILTER_LEN equal samples. Edges are detected on the filtered signals.
// - START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both are recognised in every state and take priority over bit handling.
// - START (incl. repeated) -> ADDR; bit count cleared; sda_t=1. STOP -> IDLE; busy=0; sda_t=1.
// - Abort rule: a partial byte cut by START/STOP is discarded, with no strobe issued. reg_addr (the pointer) is retained across transactions.
// - Bits: sampled on filtered SCL rise, MSB first. sda_t changes only on filtered SCL fall.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//   - ADDR, 8th rise: if byte[7:1]==DEV_ADDR, set busy=1, go to ADDR_ACK and drive SDA low from the next SCL fall until the following SCL fall. Otherwise go to IGNORE: SDA released until START/STOP.
//   - ADDR_ACK with R/W=0: go to PTR. The PTR byte loads reg_addr on its 8th rise; ACK it; then go to WDATA.
//   - WDATA, 8th rise: reg_wr_en=1 for exactly 1 clk, with reg_wr_data=byte and reg_addr=current pointer. ACK the byte. Pointer update occurs on the clk after the strobe.
//   - ADDR_ACK with R/W=1: reg_rd_en=1 on the clk after the 8th rise; reg_rd_data captured into the shift register 1 clk later. The MSB is driven at the SCL fall ending ACK.
//   - RDATA: a bit value of 0 is driven (sda_t=0); a value of 1 releases SDA. After the 8th bit, SDA is released for the master ACK.
//   - RDATA_ACK, 9th rise: if SDA=0 (ACK), update the pointer, pulse reg_rd_en and reload, then return to RDATA. If SDA=1 (NACK), go to IGNORE with SDA released.
// - Pointer arithmetic: 8-bit, wraps 8'hFF -> 8'h00.
// - Simultaneity: START/STOP on the same clk as an SCL edge -> START/STOP wins. At most one of reg_wr_en/reg_rd_en is high per clk.
// - rst_n asserted mid-byte releases SDA immediately (asynchronously).
// CONFIGURATION
// - I2C_TARGET_AUTOINC_EN defined: the pointer increments by 1 after every data write strobe and after every master-ACKed read byte.
// - I2C_TARGET_AUTOINC_EN undefined: the pointer changes only via the PTR byte. Repeated writes hit the same register; repeated reads re-read the same register.
// TESTING
// - Write 0xA0,0x10,0x55,0x66 then STOP -> two strobes. With AUTOINC: (0x10,0x55) then (0x11,0x66). Without AUTOINC: (0x10,0x55) then (0x10,0x66). All 4 bytes ACKed.
// - Write 0xA0,0x20; repeated START; 0xA1; read 2 bytes (ACK then NACK), reg_rd_data = 0x3C then 0xC3 -> SDA bytes 0x3C,0xC3. Pointer ends at 0x21 (AUTOINC) or 0x20 (without).
// - Address 0xB0 (no match) -> SDA never driven, no strobes, busy stays 0 until STOP.
// - STOP after 5 bits of a data byte -> no reg_wr_en, FSM returns to IDLE, sda_t=1.
// - rst_n low while driving ACK -> sda_t=1 asynchronously. After release, a fresh 0xA0 transaction is ACKed normally.
// - 1-clk glitch on SCL with FILTER_LEN=4 -> no bit sampled, no state change.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target serving an 8-bit register window; define I2C_TARGET_AUTOINC_EN for pointer auto-increment
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    localparam logic [3:0] FLEN_M1 = 4'(FILTER_LEN - 1);

    state_t     state_q, state_d;
    logic       scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic       scl_p_q, sda_p_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       ack_phase_q, ack_phase_d;
    logic       busy_q, busy_d;
    logic       sda_t_q, sda_t_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic       reg_wr_en_q, reg_wr_en_d;
    logic [7:0] reg_wr_data_q, reg_wr_data_d;
    logic       reg_rd_en_q, reg_rd_en_d;
    logic       rd_cap_q, rd_cap_d;
    logic [7:0] rd_q, rd_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic [2:0] rd_idx;

    // Filtered levels only move after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = 4'd0;
        if (scl_s2_q != scl_f_q) begin
            if (scl_cnt_q == FLEN_M1) scl_f_d = scl_s2_q;
            else                      scl_cnt_d = scl_cnt_q + 4'd1;
        end
        sda_f_d   = sda_f_q;
        sda_cnt_d = 4'd0;
        if (sda_s2_q != sda_f_q) begin
            if (sda_cnt_q == FLEN_M1) sda_f_d = sda_s2_q;
            else                      sda_cnt_d = sda_cnt_q + 4'd1;
        end
    end

    assign scl_rise  =  scl_f_q & ~scl_p_q;
    assign scl_fall  = ~scl_f_q &  scl_p_q;
    assign start_det =  scl_f_q &  scl_p_q &  sda_p_q & ~sda_f_q;
    assign stop_det  =  scl_f_q &  scl_p_q & ~sda_p_q &  sda_f_q;
    assign rx_byte   = {shift_q, sda_f_q};
    assign rd_idx    = ~bit_cnt_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rw_d          = rw_q;
        ack_phase_d   = ack_phase_q;
        busy_d        = busy_q;
        sda_t_d       = sda_t_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_data_d = reg_wr_data_q;
        reg_rd_en_d   = 1'b0;
        rd_cap_d      = reg_rd_en_q;
        rd_d          = rd_cap_q ? reg_rd_data : rd_q;
`ifdef I2C_TARGET_AUTOINC_EN
        if (reg_wr_en_q) reg_addr_d = reg_addr_q + 8'd1;
`endif
        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            busy_d      = 1'b0;
            sda_t_d     = 1'b1;
        end else if (stop_det) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            busy_d      = 1'b0;
            sda_t_d     = 1'b1;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_d = 1'b0;
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    busy_d      = 1'b1;
                                    rw_d        = rx_byte[0];
                                    reg_rd_en_d = rx_byte[0];
                                    state_d     = ADDR_ACK;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                reg_addr_d = rx_byte;
                                state_d    = PTR_ACK;
                            end else begin
                                reg_wr_en_d   = 1'b1;
                                reg_wr_data_d = rx_byte;
                                state_d       = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    // First fall starts the ACK low; second fall ends it
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_t_d     = 1'b0;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_t_d     = 1'b1;
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d = RDATA;
                                sda_t_d = rd_q[7];
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) sda_t_d = rd_q[rd_idx];
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) sda_t_d = 1'b1;
                    if (scl_rise) begin
                        if (!sda_f_q) begin
                            state_d     = RDATA;
                            reg_rd_en_d = 1'b1;
`ifdef I2C_TARGET_AUTOINC_EN
                            reg_addr_d  = reg_addr_q + 8'd1;
`endif
                        end else begin
                            state_d = IGNORE;
                            sda_t_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q      <= 1'b1;
            scl_s2_q      <= 1'b1;
            sda_s1_q      <= 1'b1;
            sda_s2_q      <= 1'b1;
            scl_f_q       <= 1'b1;
            sda_f_q       <= 1'b1;
            scl_cnt_q     <= 4'd0;
            sda_cnt_q     <= 4'd0;
            scl_p_q       <= 1'b1;
            sda_p_q       <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 7'd0;
            rw_q          <= 1'b0;
            ack_phase_q   <= 1'b0;
            busy_q        <= 1'b0;
            sda_t_q       <= 1'b1;
            reg_addr_q    <= 8'd0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_data_q <= 8'd0;
            reg_rd_en_q   <= 1'b0;
            rd_cap_q      <= 1'b0;
            rd_q          <= 8'd0;
        end else begin
            scl_s1_q      <= scl_i;
            scl_s2_q      <= scl_s1_q;
            sda_s1_q      <= sda_i;
            sda_s2_q      <= sda_s1_q;
            scl_f_q       <= scl_f_d;
            sda_f_q       <= sda_f_d;
            scl_cnt_q     <= scl_cnt_d;
            sda_cnt_q     <= sda_cnt_d;
            scl_p_q       <= scl_f_q;
            sda_p_q       <= sda_f_q;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rw_q          <= rw_d;
            ack_phase_q   <= ack_phase_d;
            busy_q        <= busy_d;
            sda_t_q       <= sda_t_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_rd_en_q   <= reg_rd_en_d;
            rd_cap_q      <= rd_cap_d;
            rd_q          <= rd_d;
        end
    end

    assign sda_o       = 1'b0;
    assign sda_t       = sda_t_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_rd_en   = reg_rd_en_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bench for i2c_target_regs driving an open-drain bus model
module tb_i2c_target_regs;

    localparam int Q = 100;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] reg_rd_data = 8'h00;
    logic       sda_o, sda_t, reg_wr_en, reg_rd_en, busy;
    logic [7:0] reg_addr, reg_wr_data;
    logic       sda_bus;

    assign sda_bus = sda_m & (sda_t | sda_o);

    i2c_target_regs #(.DEV_ADDR(7'h50), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_t(sda_t), .reg_addr(reg_addr),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0;
    int wr_n = 0, rd_n = 0, both_n = 0, drv_n = 0, busy_n = 0;
    logic [7:0] wr_a [16];
    logic [7:0] wr_d [16];
    logic [7:0] rd_a [16];
    logic [7:0] rd_tab [4];

    always @(negedge clk) begin
        if (reg_wr_en && reg_rd_en) both_n = both_n + 1;
        if (!sda_t) drv_n = drv_n + 1;
        if (busy) busy_n = busy_n + 1;
        if (reg_wr_en) begin
            if (wr_n < 16) begin
                wr_a[wr_n] = reg_addr;
                wr_d[wr_n] = reg_wr_data;
            end
            wr_n = wr_n + 1;
        end
        if (reg_rd_en) begin
            if (rd_n < 16) rd_a[rd_n] = reg_addr;
            reg_rd_data = (rd_n < 4) ? rd_tab[rd_n] : 8'h00;
            rd_n = rd_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        #(2*Q) scl_m = 1'b0;
    endtask

    task automatic get_ack(output logic a);
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q a = sda_bus;
        #Q scl_m = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_ack(a);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            #Q sda_m = 1'b1;
            #Q scl_m = 1'b1;
            #Q b[i] = sda_bus;
            #Q scl_m = 1'b0;
        end
        #Q sda_m = mack;
        #Q scl_m = 1'b1;
        #(2*Q) scl_m = 1'b0;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] b;
        logic [7:0] a0;
        int w0, r0, d0, b0;
        rd_tab[0] = 8'h3C;
        rd_tab[1] = 8'hC3;
        rd_tab[2] = 8'h00;
        rd_tab[3] = 8'h00;
        a0 = 8'hA0;

        #23;
        check("rst_sda_t", sda_t, 1);
        check("rst_sda_o", sda_o, 0);
        check("rst_busy", busy, 0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_strobes", {reg_wr_en, reg_rd_en}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        #(4*Q);

        // Write 0x10 <- 0x55, then 0x66
        w0 = wr_n;
        i2c_start();
        wr_byte(8'hA0, a); check("wr_addr_ack", a, 0);
        check("wr_busy", busy, 1);
        wr_byte(8'h10, a); check("wr_ptr_ack", a, 0);
        wr_byte(8'h55, a); check("wr_d0_ack", a, 0);
        wr_byte(8'h66, a); check("wr_d1_ack", a, 0);
        i2c_stop();
        #Q;
        check("wr_strobes", wr_n - w0, 2);
        check("wr0_addr", wr_a[w0], 8'h10);
        check("wr0_data", wr_d[w0], 8'h55);
        check("wr1_addr", wr_a[w0+1], AI ? 8'h11 : 8'h10);
        check("wr1_data", wr_d[w0+1], 8'h66);
        check("wr_ptr_end", reg_addr, AI ? 8'h12 : 8'h10);
        check("wr_busy_after_stop", busy, 0);

        // Pointer 0x20, repeated START, read two bytes
        w0 = wr_n; r0 = rd_n;
        i2c_start();
        wr_byte(8'hA0, a); check("rd_waddr_ack", a, 0);
        wr_byte(8'h20, a); check("rd_ptr_ack", a, 0);
        i2c_start();
        wr_byte(8'hA1, a); check("rd_raddr_ack", a, 0);
        rd_byte(1'b0, b); check("rd_byte0", b, 8'h3C);
        rd_byte(1'b1, b); check("rd_byte1", b, 8'hC3);
        i2c_stop();
        #Q;
        check("rd_strobes", rd_n - r0, 2);
        check("rd0_addr", rd_a[r0], 8'h20);
        check("rd1_addr", rd_a[r0+1], AI ? 8'h21 : 8'h20);
        check("rd_ptr_end", reg_addr, AI ? 8'h21 : 8'h20);
        check("rd_no_wr", wr_n - w0, 0);
        check("rd_busy_after_stop", busy, 0);

        // Foreign address: never driven, never busy
        w0 = wr_n; r0 = rd_n; d0 = drv_n; b0 = busy_n;
        i2c_start();
        wr_byte(8'hB0, a); check("nm_addr_nack", a, 1);
        wr_byte(8'h12, a); check("nm_data_nack", a, 1);
        i2c_stop();
        #Q;
        check("nm_drive_cycles", drv_n - d0, 0);
        check("nm_busy_cycles", busy_n - b0, 0);
        check("nm_strobes", (wr_n - w0) + (rd_n - r0), 0);

        // STOP after 5 bits of a data byte
        w0 = wr_n;
        i2c_start();
        wr_byte(8'hA0, a); check("ab_addr_ack", a, 0);
        wr_byte(8'h30, a); check("ab_ptr_ack", a, 0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        #Q;
        check("ab_no_wr", wr_n - w0, 0);
        check("ab_sda_t", sda_t, 1);
        check("ab_busy", busy, 0);
        check("ab_ptr", reg_addr, 8'h30);

        // Reset while driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(a0[i]);
        #Q sda_m = 1'b1;
        for (int k = 0; k < 60 && sda_t; k++) @(negedge clk);
        check("rs_ack_driven", sda_t, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rs_async_release", sda_t, 1);
        check("rs_async_busy", busy, 0);
        #(3*Q);
        @(negedge clk) rst_n = 1'b1;
        #Q scl_m = 1'b1;
        #(4*Q);
        i2c_start();
        wr_byte(8'hA0, a); check("rs_fresh_addr_ack", a, 0);
        wr_byte(8'h05, a); check("rs_fresh_ptr_ack", a, 0);
        i2c_stop();
        #Q;
        check("rs_fresh_ptr", reg_addr, 8'h05);

        // One-clk SCL glitch in the middle of the address byte
        i2c_start();
        for (int i = 7; i >= 4; i--) send_bit(a0[i]);
        #Q;
        @(negedge clk) scl_m = 1'b1;
        @(negedge clk) scl_m = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(a0[i]);
        get_ack(a); check("gl_addr_ack", a, 0);
        wr_byte(8'h44, a); check("gl_ptr_ack", a, 0);
        i2c_stop();
        #Q;
        check("gl_ptr", reg_addr, 8'h44);

        check("strobe_overlap", both_n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
